// File: rtl/adc_emu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_emu_pkg
//  Description : Shared constants for the serial ADC emulator: FSM state
//                encodings, sample-update mode encodings and the LFSR
//                polynomial, seed and single-step helper.
//  Revision    : 1.0  initial release
// ============================================================================
package adc_emu_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;
    localparam logic [1:0] ST_SHIFT   = 2'd3;

    // Per-frame sample update modes
    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_RAMP   = 2'b01;
    localparam logic [1:0] MODE_LFSR   = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // Galois LFSR for x^32 + x^22 + x^2 + x + 1, right-shifting form:
    // feedback lands on bit positions (tap - 1) = 31, 21, 1, 0.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hACE1_2345;

    function automatic logic [31:0] lfsr_step(input logic [31:0] state);
        return state[0] ? ((state >> 1) ^ LFSR_TAPS) : (state >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_det
//  Description : Two-flop synchroniser for an asynchronous level, plus a
//                third history flop giving single-cycle rise/fall strobes.
//                All stages reset to RESET_VAL so an input already sitting at
//                its idle level produces no edge when reset is released.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_edge_det #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic async_in,
    output logic rise_out,
    output logic fall_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Next-state of the synchroniser pipeline
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Pipeline registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_out =  sync_q & ~prev_q;
    assign fall_out = ~sync_q &  prev_q;

endmodule
`default_nettype wire

// File: rtl/adc_serial_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : adc_serial_emulator
//  Description : Multi-lane serial ADC emulator. A convst rise starts a
//                CONV_CYCLES busy window, after which the channel registers
//                are snapshotted into per-lane shift registers and shifted
//                MSB-first under the consumer's n_cs/sclk. Channel registers
//                may stay static, ramp, or follow an LFSR on channel 0.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_serial_emulator
    import adc_emu_pkg::*;
#(
    parameter int W_DATA      = 18,
    parameter int N_CHAN      = 8,
    parameter int N_LANES     = 2,
    parameter int CONV_CYCLES = 100,
    parameter int W_ADDR      = $clog2(N_CHAN)
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               convst_in,
    input  logic               n_cs_in,
    input  logic               sclk_in,
    output logic [N_LANES-1:0] data_out,
    output logic               busy_out,
    input  logic               wr_en_in,
    input  logic [W_ADDR-1:0]  wr_addr_in,
    input  logic [W_DATA-1:0]  wr_data_in,
    input  logic [1:0]         mode_in,
    output logic               frame_done_out,
    output logic               short_read_out,
    output logic               overrun_out,
    output logic [15:0]        frame_cnt_out
);

    localparam int CPL   = N_CHAN / N_LANES;        // channels per lane
    localparam int L     = W_DATA * CPL;            // bits per lane per frame
    localparam int W_CNT = $clog2(CONV_CYCLES + 1);
    localparam int W_BIT = $clog2(L + 1);

    // Synchronised edge strobes
    logic convst_rise, convst_fall;
    logic n_cs_rise, n_cs_fall;
    logic sclk_rise, sclk_fall;
    logic unused_edges;

    sync_edge_det #(.RESET_VAL(1'b0)) u_sync_convst (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .async_in (convst_in),
        .rise_out (convst_rise),
        .fall_out (convst_fall)
    );

    sync_edge_det #(.RESET_VAL(1'b1)) u_sync_n_cs (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .async_in (n_cs_in),
        .rise_out (n_cs_rise),
        .fall_out (n_cs_fall)
    );

    sync_edge_det #(.RESET_VAL(1'b1)) u_sync_sclk (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .async_in (sclk_in),
        .rise_out (sclk_rise),
        .fall_out (sclk_fall)
    );

    assign unused_edges = convst_fall ^ sclk_rise;

    // Control state
    logic [1:0]       state_q, state_d;
    logic [W_CNT-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [W_BIT-1:0] bit_cnt_q, bit_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             short_read_q, short_read_d;
    logic             overrun_q, overrun_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    // Lane datapath controls
    logic snap_en;
    logic present_en;
    logic shift_en;
    logic clear_en;

    // Sample registers
    logic [W_DATA-1:0] chan_q [N_CHAN];
    logic [W_DATA-1:0] chan_d [N_CHAN];
    logic [31:0]       lfsr_q, lfsr_d;

    // Conversion / framing state machine
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        bit_cnt_d    = bit_cnt_q;
        frame_done_d = 1'b0;
        short_read_d = 1'b0;
        overrun_d    = overrun_q;
        frame_cnt_d  = frame_cnt_q;
        snap_en      = 1'b0;
        present_en   = 1'b0;
        shift_en     = 1'b0;
        clear_en     = 1'b0;

        if (convst_rise && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (convst_rise) begin
                    state_d = ST_CONVERT;
                    busy_d  = 1'b1;
                    cnt_d   = W_CNT'(CONV_CYCLES);
                end
            end
            ST_CONVERT: begin
                cnt_d = cnt_q - W_CNT'(1);
                if (cnt_d == '0) begin
                    busy_d  = 1'b0;
                    snap_en = 1'b1;
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (n_cs_fall) begin
                    state_d    = ST_SHIFT;
                    bit_cnt_d  = '0;
                    present_en = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (n_cs_rise) begin
                    clear_en = 1'b1;
                    state_d  = ST_IDLE;
                    if (bit_cnt_q >= W_BIT'(L - 1)) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                    end else begin
                        short_read_d = 1'b1;
                    end
                end else if (sclk_fall) begin
                    shift_en = 1'b1;
                    // Saturate so over-long reads never wrap back below L-1
                    if (bit_cnt_q != W_BIT'(L)) begin
                        bit_cnt_d = bit_cnt_q + W_BIT'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            bit_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            short_read_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_done_q <= frame_done_d;
            short_read_q <= short_read_d;
            overrun_q    <= overrun_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    // Channel register update: mode step one cycle after frame_done, then a
    // host write on top so that a coincident write to the same channel wins
    always_comb begin
        lfsr_d = lfsr_q;
        for (int i = 0; i < N_CHAN; i++) begin
            chan_d[i] = chan_q[i];
        end

        if (frame_done_q) begin
            case (mode_in)
                MODE_RAMP: begin
                    for (int i = 0; i < N_CHAN; i++) begin
                        chan_d[i] = chan_q[i] + W_DATA'(1);
                    end
                end
                MODE_LFSR: begin
                    lfsr_d    = lfsr_step(lfsr_q);
                    chan_d[0] = lfsr_d[W_DATA-1:0];
                end
                MODE_STATIC, MODE_RSVD: begin
                end
            endcase
        end

        if (wr_en_in) begin
            chan_d[wr_addr_in] = wr_data_in;
        end
    end

    // Channel and LFSR registers
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            lfsr_q <= LFSR_SEED;
            for (int i = 0; i < N_CHAN; i++) begin
                chan_q[i] <= '0;
            end
        end else begin
            lfsr_q <= lfsr_d;
            for (int i = 0; i < N_CHAN; i++) begin
                chan_q[i] <= chan_d[i];
            end
        end
    end

    // Per-lane snapshot shift register and output bit
    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        logic [L-1:0] snap_w;
        logic [L-1:0] shreg_q, shreg_d;
        logic         lane_q, lane_d;

        // Lowest channel of the lane occupies the MSBs
        for (genvar c = 0; c < CPL; c++) begin : g_chan
            assign snap_w[L-1-c*W_DATA -: W_DATA] = chan_q[l*CPL + c];
        end

        // Load on snapshot, shift left with zero fill on sclk fall
        always_comb begin
            shreg_d = shreg_q;
            lane_d  = lane_q;
            if (snap_en) begin
                shreg_d = snap_w;
            end else if (shift_en) begin
                shreg_d = {shreg_q[L-2:0], 1'b0};
            end

            if (clear_en) begin
                lane_d = 1'b0;
            end else if (present_en) begin
                lane_d = shreg_q[L-1];
            end else if (shift_en) begin
                lane_d = shreg_q[L-2];
            end
        end

        // Lane registers
        always_ff @(posedge clk_in) begin
            if (!rst_n_in) begin
                shreg_q <= '0;
                lane_q  <= 1'b0;
            end else begin
                shreg_q <= shreg_d;
                lane_q  <= lane_d;
            end
        end

        assign data_out[l] = lane_q;
    end

    assign busy_out       = busy_q;
    assign frame_done_out = frame_done_q;
    assign short_read_out = short_read_q;
    assign overrun_out    = overrun_q;
    assign frame_cnt_out  = frame_cnt_q;

endmodule
`default_nettype wire
